// File: rtl/rf_result_reader.sv
// Result reader for the random-forest accumulator: pops one sample's votes or regression
// sum, reduces it to a single result (argmax label or averaged sum), and hands it downstream.
module rf_result_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int N_LABELS   = 4,
  parameter int LABEL_W    = $clog2(N_LABELS),
  parameter int RGS_SHIFT  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_is_clf,
  input  logic                             i_flush,
  output logic [N_LABELS-1:0]              o_clf_fifo_pop,
  input  logic [N_LABELS*FIFO_WIDTH-1:0]   i_clf_fifo_front,
  input  logic [N_LABELS-1:0]              i_clf_fifo_vld,
  input  logic [N_LABELS-1:0]              i_clf_fifo_is_empty,
  output logic                             o_rgs_fifo_pop,
  input  logic [FIFO_WIDTH-1:0]            i_rgs_fifo_front,
  input  logic                             i_rgs_fifo_vld,
  input  logic                             i_rgs_fifo_is_empty,
  output logic                             o_res_vld,
  input  logic                             i_res_rdy,
  output logic                             o_res_is_clf,
  output logic [LABEL_W-1:0]               o_res_label,
  output logic [FIFO_WIDTH-1:0]            o_res_value,
  output logic                             o_busy
);

  // Result handshake: a result transfers on a cycle with o_res_vld=1 and i_res_rdy=1;
  // while o_res_vld=1 and i_res_rdy=0 every o_res_* output holds its value.
  typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, OUT} state_t;

  state_t                 state;
  logic                   mode_clf;
  logic [N_LABELS-1:0]    clf_cap;
  logic [FIFO_WIDTH-1:0]  cnt_q [N_LABELS];
  logic [LABEL_W-1:0]     scan_idx;
  logic [LABEL_W-1:0]     best_idx;
  logic [FIFO_WIDTH-1:0]  best_val;

  logic                   start_clf;
  logic                   start_rgs;
  logic [N_LABELS-1:0]    clf_take;
  logic                   clf_all;
  logic                   scan_last;
  logic [FIFO_WIDTH-1:0]  scan_cur;
  logic [FIFO_WIDTH-1:0]  nxt_best_val;
  logic [LABEL_W-1:0]     nxt_best_idx;
  logic signed [FIFO_WIDTH-1:0] rgs_shifted;

  // A pop only fires when every source of the selected mode has data, so labels never pop partially.
  assign start_clf = (state == IDLE) && !i_flush && i_is_clf && !(|i_clf_fifo_is_empty);
  assign start_rgs = (state == IDLE) && !i_flush && !i_is_clf && !i_rgs_fifo_is_empty;

  assign o_clf_fifo_pop = {N_LABELS{start_clf}};
  assign o_rgs_fifo_pop = start_rgs;
  assign o_busy         = (state != IDLE);

  assign clf_take    = i_clf_fifo_vld & ~clf_cap;
  assign clf_all     = &(clf_cap | i_clf_fifo_vld);
  assign scan_last   = (scan_idx == LABEL_W'(N_LABELS - 1));
  assign scan_cur    = cnt_q[scan_idx];
  assign rgs_shifted = $signed(i_rgs_fifo_front) >>> RGS_SHIFT;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_best_val = best_val;
    nxt_best_idx = best_idx;
    if (scan_idx == '0 || scan_cur > best_val) begin
      nxt_best_val = scan_cur;
      nxt_best_idx = scan_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_clf     <= 1'b0;
      clf_cap      <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      for (int k = 0; k < N_LABELS; k++) cnt_q[k] <= '0;
      o_res_vld    <= 1'b0;
      o_res_is_clf <= 1'b0;
      o_res_label  <= '0;
      o_res_value  <= '0;
    end else if (i_flush) begin
      state     <= IDLE;
      clf_cap   <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      o_res_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_clf || start_rgs) begin
            state    <= CAPTURE;
            mode_clf <= start_clf;
            clf_cap  <= '0;
          end
        end
        CAPTURE: begin
          if (mode_clf) begin
            for (int k = 0; k < N_LABELS; k++) begin
              if (clf_take[k]) cnt_q[k] <= i_clf_fifo_front[k*FIFO_WIDTH +: FIFO_WIDTH];
            end
            clf_cap <= clf_cap | i_clf_fifo_vld;
            if (clf_all) begin
              state    <= SCAN;
              scan_idx <= '0;
            end
          end else if (i_rgs_fifo_vld) begin
            state        <= OUT;
            o_res_vld    <= 1'b1;
            o_res_is_clf <= 1'b0;
            o_res_label  <= '0;
            o_res_value  <= rgs_shifted;
          end
        end
        SCAN: begin
          best_val <= nxt_best_val;
          best_idx <= nxt_best_idx;
          scan_idx <= scan_idx + LABEL_W'(1);
          if (scan_last) begin
            state        <= OUT;
            o_res_vld    <= 1'b1;
            o_res_is_clf <= 1'b1;
            o_res_label  <= nxt_best_idx;
            o_res_value  <= nxt_best_val;
          end
        end
        OUT: begin
          if (i_res_rdy) begin
            state     <= IDLE;
            o_res_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_result_reader.sv
// Directed bench for rf_result_reader: inputs change 1ns after posedge, outputs are checked at negedge.
module tb_rf_result_reader;

  localparam int FW = 16;
  localparam int NL = 4;
  localparam int LW = 2;

  logic           clk;
  logic           rst_n;
  logic           i_is_clf;
  logic           i_flush;
  logic [NL-1:0]  o_clf_fifo_pop;
  logic [NL*FW-1:0] i_clf_fifo_front;
  logic [NL-1:0]  i_clf_fifo_vld;
  logic [NL-1:0]  i_clf_fifo_is_empty;
  logic           o_rgs_fifo_pop;
  logic [FW-1:0]  i_rgs_fifo_front;
  logic           i_rgs_fifo_vld;
  logic           i_rgs_fifo_is_empty;
  logic           o_res_vld;
  logic           i_res_rdy;
  logic           o_res_is_clf;
  logic [LW-1:0]  o_res_label;
  logic [FW-1:0]  o_res_value;
  logic           o_busy;

  int checks;
  int failures;

  rf_result_reader #(.FIFO_WIDTH(FW), .N_LABELS(NL), .LABEL_W(LW), .RGS_SHIFT(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_is_clf            (i_is_clf),
    .i_flush             (i_flush),
    .o_clf_fifo_pop      (o_clf_fifo_pop),
    .i_clf_fifo_front    (i_clf_fifo_front),
    .i_clf_fifo_vld      (i_clf_fifo_vld),
    .i_clf_fifo_is_empty (i_clf_fifo_is_empty),
    .o_rgs_fifo_pop      (o_rgs_fifo_pop),
    .i_rgs_fifo_front    (i_rgs_fifo_front),
    .i_rgs_fifo_vld      (i_rgs_fifo_vld),
    .i_rgs_fifo_is_empty (i_rgs_fifo_is_empty),
    .o_res_vld           (o_res_vld),
    .i_res_rdy           (i_res_rdy),
    .o_res_is_clf        (o_res_is_clf),
    .o_res_label         (o_res_label),
    .o_res_value         (o_res_value),
    .o_busy              (o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Classification transaction starting in the current cycle (T). d* = vld delay per label.
  task automatic clf_txn(input string tag, input logic [FW-1:0] c0, c1, c2, c3,
                         input int d0, d1, d2, d3, input int exp_lat,
                         input int exp_lbl, input logic [FW-1:0] exp_val, input int stall);
    int lat;
    int pops_seen;
    i_clf_fifo_front    = {c3, c2, c1, c0};
    i_is_clf            = 1'b1;
    i_clf_fifo_is_empty = 4'h0;
    i_res_rdy           = (stall == 0);
    @(negedge clk);
    chk({tag, "_pop"}, o_clf_fifo_pop, 4'hF);
    chk({tag, "_rgs_pop"}, o_rgs_fifo_pop, 0);
    next_cyc();
    i_clf_fifo_is_empty = 4'hF;
    i_is_clf            = 1'b0;  // mode change mid-flight must not matter
    lat = 0;
    pops_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      i_clf_fifo_vld = {(c == d3), (c == d2), (c == d1), (c == d0)};
      @(negedge clk);
      if (o_clf_fifo_pop != 0 || o_rgs_fifo_pop) pops_seen++;
      if (o_res_vld) begin
        lat = c;
        break;
      end
      next_cyc();
    end
    chk({tag, "_no_pop_wait"}, pops_seen, 0);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_label"}, o_res_label, exp_lbl);
    chk({tag, "_value"}, o_res_value, exp_val);
    chk({tag, "_is_clf"}, o_res_is_clf, 1);
    chk({tag, "_busy"}, o_busy, 1);
    for (int s = 1; s <= stall; s++) begin
      next_cyc();
      i_clf_fifo_vld      = 4'h0;
      i_is_clf            = 1'b1;
      i_clf_fifo_is_empty = 4'h0;
      if (s == stall) i_res_rdy = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_vld"}, o_res_vld, 1);
      chk({tag, "_hold_val"}, {o_res_label, o_res_value}, {exp_lbl[LW-1:0], exp_val});
      chk({tag, "_hold_nopop"}, o_clf_fifo_pop, 0);
    end
    next_cyc();
    i_clf_fifo_vld = 4'h0;
    @(negedge clk);
    chk({tag, "_busy_after"}, o_busy, 0);
    chk({tag, "_vld_after"}, o_res_vld, 0);
    chk({tag, "_pop_after"}, o_clf_fifo_pop, (stall > 0) ? 4'hF : 4'h0);
    if (stall > 0) begin
      // abort the transaction that the post-handshake pop started
      next_cyc();
      i_clf_fifo_is_empty = 4'hF;
      i_flush = 1'b1;
      next_cyc();
      i_flush = 1'b0;
      @(negedge clk);
      chk({tag, "_flush_idle"}, o_busy, 0);
    end
    next_cyc();
    i_res_rdy = 1'b0;
  endtask

  task automatic rgs_txn(input string tag, input logic [FW-1:0] front, input logic [FW-1:0] exp_val);
    i_is_clf            = 1'b0;
    i_rgs_fifo_is_empty = 1'b0;
    i_rgs_fifo_front    = front;
    i_res_rdy           = 1'b1;
    @(negedge clk);
    chk({tag, "_pop"}, o_rgs_fifo_pop, 1);
    chk({tag, "_clf_pop"}, o_clf_fifo_pop, 0);
    next_cyc();
    i_rgs_fifo_is_empty = 1'b1;
    i_rgs_fifo_vld      = 1'b1;
    @(negedge clk);
    chk({tag, "_vld_t1"}, o_res_vld, 0);
    next_cyc();
    i_rgs_fifo_vld = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_t2"}, o_res_vld, 1);
    chk({tag, "_value"}, o_res_value, exp_val);
    chk({tag, "_label"}, o_res_label, 0);
    chk({tag, "_is_clf"}, o_res_is_clf, 0);
    next_cyc();
    @(negedge clk);
    chk({tag, "_busy_after"}, o_busy, 0);
    next_cyc();
    i_res_rdy = 1'b0;
  endtask

  initial begin
    int seen;
    checks   = 0;
    failures = 0;
    rst_n               = 1'b0;
    i_is_clf            = 1'b1;
    i_flush             = 1'b0;
    i_clf_fifo_front    = '0;
    i_clf_fifo_vld      = '0;
    i_clf_fifo_is_empty = 4'hF;
    i_rgs_fifo_front    = '0;
    i_rgs_fifo_vld      = 1'b0;
    i_rgs_fifo_is_empty = 1'b1;
    i_res_rdy           = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld", o_res_vld, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_out", {o_res_is_clf, o_res_label, o_res_value}, 0);
    chk("rst_pop", {o_clf_fifo_pop, o_rgs_fifo_pop}, 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Basic classification: tie 7/7 resolves to label 1
    clf_txn("t1", 16'd3, 16'd7, 16'd2, 16'd7, 1, 1, 1, 1, 6, 1, 16'd7, 0);

    // Regression averaging with floor rounding
    rgs_txn("t2a", 16'hFFF0, 16'hFFFC);
    rgs_txn("t2b", 16'h0013, 16'h0004);
    rgs_txn("t2c", 16'h8001, 16'hE000);

    // Backpressure for 5 cycles, handshake on the 6th
    clf_txn("t3", 16'd10, 16'd2, 16'd30, 16'd30, 1, 1, 1, 1, 6, 2, 16'd30, 5);

    // One empty label blocks every pop
    i_is_clf            = 1'b1;
    i_clf_fifo_is_empty = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_nopop", o_clf_fifo_pop, 0);
      chk("t4_idle", o_busy, 0);
      next_cyc();
    end
    clf_txn("t4", 16'd1, 16'd0, 16'd2, 16'd0, 1, 1, 1, 1, 6, 2, 16'd2, 0);

    // Skewed valid: last vld at T+3 gives SCAN at T+4 and result at T+8
    clf_txn("t5", 16'd1, 16'd4, 16'd9, 16'd6, 1, 3, 3, 3, 8, 2, 16'd9, 0);

    // Flush during SCAN, then flush while IDLE with data ready
    i_clf_fifo_front    = {16'd4, 16'd3, 16'd2, 16'd1};
    i_is_clf            = 1'b1;
    i_clf_fifo_is_empty = 4'h0;
    @(negedge clk);
    chk("t5f_pop", o_clf_fifo_pop, 4'hF);
    next_cyc();
    i_clf_fifo_is_empty = 4'hF;
    i_clf_fifo_vld      = 4'hF;
    next_cyc();
    i_clf_fifo_vld = 4'h0;
    next_cyc();
    i_flush = 1'b1;
    @(negedge clk);
    chk("t5f_busy_scan", o_busy, 1);
    next_cyc();
    i_clf_fifo_is_empty = 4'h0;
    @(negedge clk);
    chk("t5f_idle", o_busy, 0);
    chk("t5f_flush_nopop", o_clf_fifo_pop, 0);
    next_cyc();
    i_flush             = 1'b0;
    i_clf_fifo_is_empty = 4'hF;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      i_clf_fifo_vld = (i == 1) ? 4'hF : 4'h0;  // late vld after the flush
      @(negedge clk);
      if (o_res_vld || o_busy) seen++;
      next_cyc();
    end
    i_clf_fifo_vld = 4'h0;
    chk("t5f_no_result", seen, 0);

    // Ties go to label 0; unsigned compare on max value
    clf_txn("t6a", 16'd5, 16'd5, 16'd5, 16'd5, 1, 1, 1, 1, 6, 0, 16'd5, 0);
    clf_txn("t6b", 16'd0, 16'd0, 16'd0, 16'hFFFF, 1, 1, 1, 1, 6, 3, 16'hFFFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_result_reader.md
Name: rf_result_reader

Overview:
- Drains the accumulator's output side and turns it into one final result per input sample.
- In classification mode it pops one vote count from every label FIFO and picks the argmax label by a sequential scan.
- In regression mode it pops the summed prediction from the regression FIFO and averages it by an arithmetic right shift.
- The result goes to the host/AXI wrapper over a valid/ready handshake.

Parameters:
- FIFO_WIDTH, 16, width of each FIFO entry (vote count or regression sum).
- N_LABELS, 4, number of classification label FIFOs (≥2).
- LABEL_W, $clog2(N_LABELS), width of the label index output.
- RGS_SHIFT, 2, arithmetic right shift applied to the regression sum (log2 of the tree count).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_is_clf  input  1  1 = classification, 0 = regression; sampled only in IDLE.
- i_flush  input  1  synchronous abort, same flush that empties the accumulator FIFOs.
- o_clf_fifo_pop  output  N_LABELS  per-label pop.
- i_clf_fifo_front  input  N_LABELS*FIFO_WIDTH  per-label vote count, unsigned; label k in bits [k*FIFO_WIDTH +: FIFO_WIDTH].
- i_clf_fifo_vld  input  N_LABELS  per-label data valid.
- i_clf_fifo_is_empty  input  N_LABELS  per-label empty.
- o_rgs_fifo_pop  output  1  regression pop.
- i_rgs_fifo_front  input  FIFO_WIDTH  regression sum, two's complement.
- i_rgs_fifo_vld  input  1  regression data valid.
- i_rgs_fifo_is_empty  input  1  regression empty.
- o_res_vld  output  1  result valid.
- i_res_rdy  input  1  downstream ready.
- o_res_is_clf  output  1  mode of the current result.
- o_res_label  output  LABEL_W  winning label (classification); 0 in regression.
- o_res_value  output  FIFO_WIDTH  winning vote count (classification) or shifted sum (regression).
- o_busy  output  1  FSM not in IDLE.

Behaviour:

Reset (async, rst_n=0):
- All outputs 0; FSM in IDLE; all latches and the scan index cleared.

FSM states: IDLE, CAPTURE, SCAN, OUT.

IDLE:
- Classification (i_is_clf=1, all i_clf_fifo_is_empty=0): o_clf_fifo_pop = all ones for exactly this cycle. Pop is combinational from state and inputs. Mode is latched and the FSM goes to CAPTURE.
- Regression (i_is_clf=0, i_rgs_fifo_is_empty=0): o_rgs_fifo_pop=1 for one cycle; go to CAPTURE.
- Otherwise stay in IDLE with no pop.
- No partial pop ever occurs: if any label FIFO is empty, no label FIFO is popped.

CAPTURE:
- Each FIFO asserts vld with its data on some cycle ≥ T+1, where T is the pop cycle.
- Per-source latch: the front is stored on a cycle with vld=1 and a sticky captured bit is set.
- Vld on a source whose captured bit is already set is ignored.
- When all required captured bits are set (including the same cycle as the last vld), go to SCAN (classification) or OUT (regression).
- With nominal FIFOs (vld at T+1): classification enters SCAN at T+2; regression enters OUT at T+2 with o_res_vld=1.

SCAN (one label per cycle, index i = 0..N_LABELS-1):
- At i=0: best_val=count[0], best_idx=0.
- For i>0: update only if count[i] > best_val (unsigned, strict). Ties go to the lowest index.
- After index N_LABELS-1, go to OUT. o_res_vld first rises at T+2+N_LABELS (T+6 for the defaults).

OUT:
- o_res_vld=1; o_res_is_clf, o_res_label and o_res_value are held stable until the cycle where i_res_rdy=1.
- On that handshake cycle, go to IDLE. The next pop can occur one cycle after the handshake. No pop ever occurs while in OUT.

Regression value:
- o_res_value = sign-extending arithmetic right shift by RGS_SHIFT (floor rounding); o_res_label=0.

i_flush (highest priority, any state):
- The next state is IDLE.
- All captured bits, best_val/best_idx and o_res_vld clear at the next edge.
- In the cycle i_flush=1, all pops are forced to 0 even when in IDLE.
- Vld arriving after a flush is ignored.

i_is_clf changes:
- A change outside IDLE has no effect on the transaction in flight.

Test Plan:
1. Classification, counts {3,7,2,7} (labels 0..3), vld at T+1, i_res_rdy=1 → single-cycle pop of 4'b1111 at T; o_res_vld at T+6 with label=1, value=7, is_clf=1; o_busy falls after the handshake.
2. Regression, front=16'hFFF0 (−16), RGS_SHIFT=2 → pop at T, o_res_vld at T+2 with value=16'hFFFC (−4), label=0, is_clf=0. Repeat with 16'h0013 → value 16'h0004.
3. Backpressure: i_res_rdy held 0 for 5 cycles in OUT while FIFOs are non-empty → outputs stable, no pops. Handshake on the 6th cycle → next pop exactly one cycle later.
4. Label 2 FIFO empty, others non-empty, i_is_clf=1 → o_clf_fifo_pop stays 0 and FSM stays in IDLE. Deassert empty → pop on that cycle.
5. Skewed vld: label 0 vld at T+1, labels 1-3 at T+3 → SCAN starts at T+4 and the result is correct. Flush asserted during SCAN → IDLE next cycle, o_res_vld never asserts, no pop in the flush cycle.
6. All counts equal (5,5,5,5) → label 0. Counts {0,0,0,16'hFFFF} → label 3, value 16'hFFFF (unsigned compare).
